// File: rtl/ccd_seq_pkg.sv
// Shared definitions for the CCD pixel sequencer: FSM encoding and config limits.
package ccd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int MIN_PERIOD = 4;

endpackage

// File: rtl/ccd_phase_gen.sv
// Phase/pixel counters and the registered CCD timing outputs (clk, shp, shd, clpdm).
module ccd_phase_gen #(
    parameter int PER_W     = 9,
    parameter int PIX_W     = 8,
    parameter int BLANK_LEN = 10
) (
    input  logic             sys_clk,
    input  logic             n_rst,
    input  logic             go,
    input  logic             active,
    input  logic [PER_W-1:0] period,
    input  logic [PER_W-1:0] shp_lo,
    input  logic [PER_W-1:0] shp_hi,
    input  logic [PER_W-1:0] shd_lo,
    input  logic [PER_W-1:0] shd_hi,
    input  logic [PIX_W-1:0] line_len,
    output logic [PER_W-1:0] phase,
    output logic [PIX_W-1:0] pix,
    output logic             wrap,
    output logic             clk_fpga,
    output logic             shp_fpga,
    output logic             shd_fpga,
    output logic             clpdm_fpga
);

    logic [PER_W-1:0] phase_q, phase_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             clk_q, clk_d, shp_q, shp_d, shd_q, shd_d, clpdm_q, clpdm_d;
    logic [PER_W-1:0] half;

    assign half  = period >> 1;
    assign wrap  = (phase_q == period - PER_W'(1));

    always_comb begin
        phase_d = phase_q;
        pix_d   = pix_q;
        clk_d   = clk_q;
        shp_d   = shp_q;
        shd_d   = shd_q;
        clpdm_d = clpdm_q;
        if (!active) begin
            phase_d = '0;
            pix_d   = '0;
            clk_d   = 1'b1;
            shp_d   = 1'b1;
            shd_d   = 1'b1;
            clpdm_d = 1'b0;
        end else if (go) begin
            // line_len > BLANK_LEN is guaranteed by the start check, so pixel 0 is unblanked
            phase_d = '0;
            pix_d   = '0;
            clk_d   = 1'b1;
            shp_d   = 1'b1;
            shd_d   = 1'b1;
            clpdm_d = 1'b1;
        end else begin
            phase_d = wrap ? '0 : phase_q + PER_W'(1);
            if (wrap)
                pix_d = (pix_q == line_len - PIX_W'(1)) ? '0 : pix_q + PIX_W'(1);
            clk_d = (phase_d < half);
            if (phase_q == shp_lo)      shp_d = 1'b0;
            else if (phase_q == shp_hi) shp_d = 1'b1;
            if (phase_q == shd_lo)      shd_d = 1'b0;
            else if (phase_q == shd_hi) shd_d = 1'b1;
            if (wrap)
                clpdm_d = (pix_d < line_len - PIX_W'(BLANK_LEN));
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q <= '0;
            pix_q   <= '0;
            clk_q   <= 1'b1;
            shp_q   <= 1'b1;
            shd_q   <= 1'b1;
            clpdm_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pix_q   <= pix_d;
            clk_q   <= clk_d;
            shp_q   <= shp_d;
            shd_q   <= shd_d;
            clpdm_q <= clpdm_d;
        end
    end

    assign phase      = phase_q;
    assign pix        = pix_q;
    assign clk_fpga   = clk_q;
    assign shp_fpga   = shp_q;
    assign shd_fpga   = shd_q;
    assign clpdm_fpga = clpdm_q;

endmodule

// File: rtl/ccd_pixel_sequencer.sv
// CCD pixel sequencer top: run FSM, config latch, sample-to-DAC path and status flags.
module ccd_pixel_sequencer
    import ccd_seq_pkg::*;
#(
    parameter int DAC_W     = 14,
    parameter int PER_W     = 9,
    parameter int PIX_W     = 8,
    parameter int BLANK_LEN = 10
) (
    input  logic             sys_clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [PER_W-1:0] cfg_shp_lo,
    input  logic [PER_W-1:0] cfg_shp_hi,
    input  logic [PER_W-1:0] cfg_shd_lo,
    input  logic [PER_W-1:0] cfg_shd_hi,
    input  logic             cfg_ccd,
    input  logic [DAC_W-1:0] cfg_black,
    input  logic [PIX_W-1:0] cfg_line_len,
    input  logic [DAC_W-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [DAC_W-1:0] dac_d,
    output logic             clk_fpga,
    output logic             shp_fpga,
    output logic             shd_fpga,
    output logic             clpdm_fpga,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic             cfg_err
);

    state_e           state_q, state_d;
    logic [PER_W-1:0] per_q, per_d, shp_lo_q, shp_lo_d, shp_hi_q, shp_hi_d;
    logic [PER_W-1:0] shd_lo_q, shd_lo_d, shd_hi_q, shd_hi_d;
    logic             ccd_q, ccd_d;
    logic [DAC_W-1:0] black_q, black_d, smp_q, smp_d, dac_code_q, dac_code_d;
    logic [PIX_W-1:0] len_q, len_d;
    logic             underrun_q, underrun_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic             go, cfg_ok, wrap, mid;
    logic [PER_W-1:0] phase, half;
    logic [PIX_W-1:0] pix;

    assign cfg_ok  = (cfg_period >= PER_W'(MIN_PERIOD)) && (cfg_line_len > PIX_W'(BLANK_LEN));
    assign half    = per_q >> 1;
    assign mid     = ccd_q && (phase == half - PER_W'(1));
    assign s_ready = (state_q == RUN) && wrap && s_valid;

    always_comb begin
        state_d    = state_q;
        per_d      = per_q;
        shp_lo_d   = shp_lo_q;
        shp_hi_d   = shp_hi_q;
        shd_lo_d   = shd_lo_q;
        shd_hi_d   = shd_hi_q;
        ccd_d      = ccd_q;
        black_d    = black_q;
        len_d      = len_q;
        smp_d      = smp_q;
        dac_code_d = dac_code_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        go         = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (cfg_ok) begin
                    go         = 1'b1;
                    state_d    = RUN;
                    per_d      = cfg_period;
                    shp_lo_d   = cfg_shp_lo;
                    shp_hi_d   = cfg_shp_hi;
                    shd_lo_d   = cfg_shd_lo;
                    shd_hi_d   = cfg_shd_hi;
                    ccd_d      = cfg_ccd;
                    black_d    = cfg_black;
                    len_d      = cfg_line_len;
                    underrun_d = 1'b0;
                    // pixel 0 is the fetch slot for the first sample, so it shows black
                    smp_d      = cfg_black;
                    dac_code_d = cfg_black;
                end else begin
                    cfg_err_d = 1'b1;
                end
            end
            RUN: if (abort) begin
                state_d = IDLE;
            end else if (wrap) begin
                if (s_valid) begin
                    smp_d = s_data;
                    if (s_last) state_d = FLUSH;
                end else begin
                    smp_d      = black_q;
                    underrun_d = 1'b1;
                end
                dac_code_d = ccd_q ? black_q : smp_d;
            end else if (mid) begin
                dac_code_d = smp_q;
            end
            FLUSH: if (abort) begin
                state_d = IDLE;
            end else if (wrap) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (mid) begin
                dac_code_d = smp_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            per_q      <= '0;
            shp_lo_q   <= '0;
            shp_hi_q   <= '0;
            shd_lo_q   <= '0;
            shd_hi_q   <= '0;
            ccd_q      <= 1'b0;
            black_q    <= '0;
            len_q      <= '0;
            smp_q      <= '0;
            dac_code_q <= '0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_q      <= per_d;
            shp_lo_q   <= shp_lo_d;
            shp_hi_q   <= shp_hi_d;
            shd_lo_q   <= shd_lo_d;
            shd_hi_q   <= shd_hi_d;
            ccd_q      <= ccd_d;
            black_q    <= black_d;
            len_q      <= len_d;
            smp_q      <= smp_d;
            dac_code_q <= dac_code_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    ccd_phase_gen #(
        .PER_W    (PER_W),
        .PIX_W    (PIX_W),
        .BLANK_LEN(BLANK_LEN)
    ) u_phase_gen (
        .sys_clk   (sys_clk),
        .n_rst     (n_rst),
        .go        (go),
        .active    (state_d != IDLE),
        .period    (per_q),
        .shp_lo    (shp_lo_q),
        .shp_hi    (shp_hi_q),
        .shd_lo    (shd_lo_q),
        .shd_hi    (shd_hi_q),
        .line_len  (len_q),
        .phase     (phase),
        .pix       (pix),
        .wrap      (wrap),
        .clk_fpga  (clk_fpga),
        .shp_fpga  (shp_fpga),
        .shd_fpga  (shd_fpga),
        .clpdm_fpga(clpdm_fpga)
    );

    assign dac_d    = dac_code_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign underrun = underrun_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_ccd_pixel_sequencer.sv
// Scoreboard bench: runs push per-cycle expected output records, a monitor pops and compares.
module tb_ccd_pixel_sequencer;

    localparam int DAC_W = 14;
    localparam int PER_W = 9;
    localparam int PIX_W = 8;
    localparam int BLANK = 10;

    typedef logic [DAC_W+5:0] rec_t;   // {dac, clk, shp, shd, clpdm, busy, done}

    logic             sys_clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [PER_W-1:0] cfg_period = '0, cfg_shp_lo = '0, cfg_shp_hi = '0;
    logic [PER_W-1:0] cfg_shd_lo = '0, cfg_shd_hi = '0;
    logic             cfg_ccd = 1'b0;
    logic [DAC_W-1:0] cfg_black = '0;
    logic [PIX_W-1:0] cfg_line_len = '0;
    logic [DAC_W-1:0] s_data = '0;
    logic             s_valid = 1'b0, s_last = 1'b0;
    logic             s_ready, clk_fpga, shp_fpga, shd_fpga, clpdm_fpga;
    logic             busy, done, underrun, cfg_err;
    logic [DAC_W-1:0] dac_d;

    int   checks = 0;
    int   fails = 0;
    rec_t exp_q[$];

    logic [DAC_W-1:0] drv_smp[32];
    int drv_n = 0, drv_idx = 0, drv_gap = -1, drv_gap_cnt = 0, drv_period = 4;
    bit drv_en = 1'b0;

    ccd_pixel_sequencer #(
        .DAC_W(DAC_W), .PER_W(PER_W), .PIX_W(PIX_W), .BLANK_LEN(BLANK)
    ) dut (
        .sys_clk(sys_clk), .n_rst(n_rst), .start(start), .abort(abort),
        .cfg_period(cfg_period), .cfg_shp_lo(cfg_shp_lo), .cfg_shp_hi(cfg_shp_hi),
        .cfg_shd_lo(cfg_shd_lo), .cfg_shd_hi(cfg_shd_hi), .cfg_ccd(cfg_ccd),
        .cfg_black(cfg_black), .cfg_line_len(cfg_line_len),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .dac_d(dac_d), .clk_fpga(clk_fpga), .shp_fpga(shp_fpga), .shd_fpga(shd_fpga),
        .clpdm_fpga(clpdm_fpga), .busy(busy), .done(done), .underrun(underrun),
        .cfg_err(cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp_v);
        end
    endtask

    // Sample source: continuous s_valid, optionally dropped for one full pixel before sample drv_gap.
    initial begin : driver
        forever begin
            @(negedge sys_clk);
            if (drv_gap_cnt > 0) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                drv_gap_cnt--;
            end else if (drv_en && drv_idx < drv_n) begin
                s_valid = 1'b1;
                s_data  = drv_smp[drv_idx];
                s_last  = (drv_idx == drv_n - 1);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            #1;
            if (s_ready) begin
                drv_idx++;
                if (drv_idx == drv_gap) drv_gap_cnt = drv_period;
            end
        end
    end

    initial begin : monitor
        rec_t act, e_rec;
        forever begin
            @(negedge sys_clk);
            if (n_rst && (busy || done)) begin
                act = {dac_d, clk_fpga, shp_fpga, shd_fpga, clpdm_fpga, busy, done};
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra act=%h exp=none", act);
                end else begin
                    e_rec = exp_q.pop_front();
                    if (act !== e_rec) begin
                        fails++;
                        $display("FAIL stream act=%h exp=%h", act, e_rec);
                    end
                end
            end
        end
    end

    // Expected waveform: pixel 0 is black (fetch slot), then one pixel per sample,
    // with an extra black pixel before sample 'gap'. limit<0 means full run plus done.
    task automatic build_exp(input int per, input int lo_p, input int hi_p, input int lo_d,
                             input int hi_d, input bit ccd, input logic [DAC_W-1:0] blk,
                             input int ll, input int n, input int gap, input int limit);
        logic [DAC_W-1:0] pixv[$];
        logic [DAC_W-1:0] dv;
        logic shp_l = 1'b1, shd_l = 1'b1, clk_e, clp_e;
        int   cnt = 0;
        rec_t r;
        pixv.push_back(blk);
        for (int i = 0; i < n; i++) begin
            if (i == gap) pixv.push_back(blk);
            pixv.push_back(drv_smp[i]);
        end
        for (int k = 0; k < pixv.size(); k++) begin
            for (int p = 0; p < per; p++) begin
                if (limit >= 0 && cnt == limit) return;
                dv    = (ccd && p < per / 2) ? blk : pixv[k];
                clk_e = (p < per / 2);
                clp_e = ((k % ll) < ll - BLANK);
                r     = {dv, clk_e, shp_l, shd_l, clp_e, 1'b1, 1'b0};
                exp_q.push_back(r);
                cnt++;
                if (p == lo_p) shp_l = 1'b0; else if (p == hi_p) shp_l = 1'b1;
                if (p == lo_d) shd_l = 1'b0; else if (p == hi_d) shd_l = 1'b1;
            end
        end
        if (limit < 0) begin
            r = {pixv[pixv.size()-1], 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            exp_q.push_back(r);
        end
    endtask

    task automatic drv_setup(input int n, input int gap, input int per);
        drv_n = n; drv_gap = gap; drv_period = per;
        drv_idx = 0; drv_gap_cnt = 0; drv_en = 1'b1;
    endtask

    task automatic do_start(input int per, input int lo_p, input int hi_p, input int lo_d,
                            input int hi_d, input bit ccd, input logic [DAC_W-1:0] blk,
                            input int ll);
        cfg_period = PER_W'(per);  cfg_shp_lo = PER_W'(lo_p); cfg_shp_hi = PER_W'(hi_p);
        cfg_shd_lo = PER_W'(lo_d); cfg_shd_hi = PER_W'(hi_d); cfg_ccd = ccd;
        cfg_black  = blk;          cfg_line_len = PIX_W'(ll);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check({nm, "_in_time"}, 32'(n < budget), 32'd1);
        check({nm, "_leftover"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_full(input string nm, input int per, input int lo_p, input int hi_p,
                            input int lo_d, input int hi_d, input bit ccd,
                            input logic [DAC_W-1:0] blk, input int ll, input int n,
                            input int gap, input bit poke);
        drv_setup(n, gap, per);
        build_exp(per, lo_p, hi_p, lo_d, hi_d, ccd, blk, ll, n, gap, -1);
        @(negedge sys_clk);
        do_start(per, lo_p, hi_p, lo_d, hi_d, ccd, blk, ll);
        if (poke) begin
            // a start with a different period mid-run must not disturb anything
            @(negedge sys_clk);
            cfg_period = PER_W'(8);
            start = 1'b1;
            @(negedge sys_clk);
            start = 1'b0;
        end
        wait_drain(nm, 2000);
        repeat (2) @(negedge sys_clk);
        drv_en = 1'b0;
        @(negedge sys_clk);
    endtask

    // Plain run, period 4, abort asserted during cycle c (cycle 0 = first busy cycle).
    task automatic run_abort(input string nm, input int n, input int c);
        drv_setup(n, -1, 4);
        build_exp(4, 0, 2, 1, 3, 1'b0, 14'h0200, 16, n, -1, c + 1);
        @(negedge sys_clk);
        do_start(4, 0, 2, 1, 3, 1'b0, 14'h0200, 16);
        repeat (c) @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_levels"}, 32'({clk_fpga, shp_fpga, shd_fpga, clpdm_fpga}), 32'hE);
        check({nm, "_done"}, 32'(done), 32'd0);
        repeat (4) @(negedge sys_clk);
        check({nm, "_leftover"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        drv_en = 1'b0;
        @(negedge sys_clk);
    endtask

    initial begin : stim
        repeat (3) @(negedge sys_clk);
        check("rst_dac", 32'(dac_d), 32'd0);
        check("rst_levels", 32'({clk_fpga, shp_fpga, shd_fpga, clpdm_fpga}), 32'hE);
        check("rst_flags", 32'({s_ready, busy, done, underrun, cfg_err}), 32'd0);
        n_rst = 1'b1;
        @(negedge sys_clk);

        // CCD run: period 8, shp 1/3, shd 5/7, black 0x100, 16-pixel line, 20 samples
        for (int i = 0; i < 20; i++) drv_smp[i] = DAC_W'(14'h0200 + i * 14'h0123);
        run_full("ccd", 8, 1, 3, 5, 7, 1'b1, 14'h0100, 16, 20, -1, 1'b0);
        check("ccd_underrun", 32'(underrun), 32'd0);

        // plain run with full-scale and minimum codes, plus an ignored start mid-run
        drv_smp[0] = 14'h3FFF;
        drv_smp[1] = 14'h0001;
        run_full("plain", 4, 0, 2, 1, 3, 1'b0, 14'h0200, 16, 2, -1, 1'b1);

        // underrun: second sample slot starved
        drv_smp[0] = 14'h0AAA; drv_smp[1] = 14'h1234; drv_smp[2] = 14'h2F0F;
        run_full("underrun", 4, 0, 2, 1, 3, 1'b0, 14'h0155, 16, 3, 1, 1'b0);
        check("underrun_flag", 32'(underrun), 32'd1);

        // next start clears the sticky flag
        drv_smp[0] = 14'h0777; drv_smp[1] = 14'h0888;
        run_full("restart", 4, 0, 2, 1, 3, 1'b1, 14'h0040, 12, 2, -1, 1'b0);
        check("underrun_cleared", 32'(underrun), 32'd0);

        // rejected configurations
        do_start(3, 0, 1, 1, 2, 1'b0, 14'h0100, 16);
        check("bad_period_err", 32'(cfg_err), 32'd1);
        check("bad_period_busy", 32'(busy), 32'd0);
        @(negedge sys_clk);
        check("bad_period_pulse", 32'(cfg_err), 32'd0);
        do_start(8, 1, 3, 5, 7, 1'b0, 14'h0100, BLANK);
        check("bad_len_err", 32'(cfg_err), 32'd1);
        check("bad_len_busy", 32'(busy), 32'd0);
        @(negedge sys_clk);

        // abort during pixel 5 (phase 2), and abort racing the s_last acceptance
        for (int i = 0; i < 10; i++) drv_smp[i] = DAC_W'(14'h0300 + i);
        run_abort("abort_px5", 10, 5 * 4 + 2);
        run_abort("abort_last", 2, 2 * 4 - 1);

        // reset asserted mid-run, then a normal run
        drv_setup(6, -1, 4);
        build_exp(4, 0, 2, 1, 3, 1'b0, 14'h0200, 16, 6, -1, 7);
        @(negedge sys_clk);
        do_start(4, 0, 2, 1, 3, 1'b0, 14'h0200, 16);
        repeat (6) @(negedge sys_clk);
        #3 n_rst = 1'b0;
        #1;
        check("midrst_dac", 32'(dac_d), 32'd0);
        check("midrst_levels", 32'({clk_fpga, shp_fpga, shd_fpga, clpdm_fpga}), 32'hE);
        check("midrst_flags", 32'({busy, done, underrun, cfg_err}), 32'd0);
        check("midrst_leftover", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        drv_en = 1'b0;
        @(negedge sys_clk);
        n_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_no_done", 32'(done), 32'd0);
        drv_smp[0] = 14'h1111; drv_smp[1] = 14'h2222; drv_smp[2] = 14'h3333;
        run_full("after_rst", 4, 0, 2, 1, 3, 1'b1, 14'h0080, 16, 3, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/ccd_pixel_sequencer.md
CCD_PIXEL_SEQUENCER -- requirements
Module: ccd_pixel_sequencer

Interface
REQ-001 SHALL have parameter DAC_W, default 14, the DAC sample width.
REQ-002 SHALL have parameter PER_W, default 9, the width of the pixel-period counter.
REQ-003 SHALL have parameter PIX_W, default 8, the width of the pixel index and line length.
REQ-004 SHALL have parameter BLANK_LEN, default 10, the number of trailing pixels per line with clpdm low.
REQ-005 SHALL have these ports, one per line: name, direction, width, meaning.
- sys_clk  in  1  single clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a run.
- abort  in  1  one-cycle pulse; ends a run immediately.
- cfg_period  in  PER_W  clock cycles per pixel.
- cfg_shp_lo, cfg_shp_hi, cfg_shd_lo, cfg_shd_hi  in  PER_W each  phase values at which the shp/shd edges occur.
- cfg_ccd  in  1  1 = CCD mode (black, then video); 0 = plain-ADC mode.
- cfg_black  in  DAC_W  black-level code.
- cfg_line_len  in  PIX_W  pixels per line.
- s_data  in  DAC_W  sample word.
- s_valid  in  1  sample available.
- s_last  in  1  marks the final sample.
- s_ready  out  1  sample accepted this cycle.
- dac_d  out  DAC_W  registered DAC code.
- clk_fpga, shp_fpga, shd_fpga, clpdm_fpga  out  1 each  CCD timing outputs.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse at run completion.
- underrun  out  1  sticky flag; cleared by start.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-006 SHALL implement the states IDLE, RUN and FLUSH.
REQ-007 In IDLE, start with cfg_period>=4 and cfg_line_len>BLANK_LEN SHALL latch all cfg_* values, clear underrun, and enter RUN on the next cycle with phase=0 and pix=0.
REQ-008 In IDLE, start with an invalid configuration SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-009 The phase counter SHALL count 0..period-1 and then wrap to 0.
REQ-010 pix SHALL increment at every phase wrap and wrap from line_len-1 to 0.
REQ-011 s_ready SHALL be high exactly when state=RUN, phase=period-1 and s_valid=1; nowhere else.
REQ-012 An accepted sample SHALL be placed on dac_d at the edge where phase becomes 0.
- Latency: 1 cycle from acceptance to dac_d.
REQ-013 In CCD mode, dac_d SHALL equal black during phase [0, period>>1) and the sample during [period>>1, period).
REQ-014 In plain mode, dac_d SHALL hold the sample for the whole pixel.
REQ-015 clk_fpga SHALL be 1 for phase < period>>1 and 0 otherwise.
REQ-016 shp_fpga SHALL go low at phase=shp_lo and high at phase=shp_hi.
REQ-017 shd_fpga SHALL go low at phase=shd_lo and high at phase=shd_hi.
REQ-018 The shp/shd edges SHALL be registered, so each edge appears one cycle after the matching phase.
REQ-019 clpdm_fpga SHALL be 1 while pix < line_len-BLANK_LEN and 0 otherwise.
- Evaluated at phase 0 of each pixel.
REQ-020 Underrun (s_valid=0 at phase=period-1 in RUN) SHALL set underrun and output the black level for the whole next pixel.
- Timing outputs continue unchanged.
REQ-021 Acceptance of a sample with s_last=1 SHALL enter FLUSH.
REQ-022 In FLUSH, s_ready SHALL stay 0 while the final pixel completes.
REQ-023 At the FLUSH phase wrap, the block SHALL pulse done, enter IDLE and deassert busy.
REQ-024 abort in RUN or FLUSH SHALL return to IDLE on the next edge, force the idle output levels, and produce no done pulse.
REQ-025 abort SHALL take priority over s_last acceptance in the same cycle.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 start and abort together in IDLE SHALL be treated as start.
REQ-028 Idle output levels SHALL be clk/shp/shd=1 and clpdm=0, with dac_d holding its last value.
REQ-029 busy SHALL be 1 exactly in RUN and FLUSH.
REQ-030 Phase comparisons SHALL be unsigned PER_W-bit.
- A phase value >= period never matches, so that edge never toggles.

Reset
REQ-031 On n_rst low, all of the following SHALL reset asynchronously:
- state=IDLE, phase=0, pix=0, dac_d=0;
- clk/shp/shd=1, clpdm=0;
- s_ready, busy, done, underrun and cfg_err=0;
- latched cfg_* = 0.
REQ-032 Reset asserted mid-run SHALL discard any in-flight sample without producing done.

Structure
REQ-033 Shared package ccd_seq_pkg SHALL hold the state encoding (IDLE=0, RUN=1, FLUSH=2) and MIN_PERIOD=4.
REQ-034 Phase/pixel counting and edge decode SHALL reside in sub-module ccd_phase_gen.
- ccd_phase_gen outputs phase, pix, wrap and the registered clk/shp/shd/clpdm.
REQ-035 The FSM, sample path and flags SHALL reside in the top module.

Verification
REQ-036 CCD run: period=8, shp 1/3, shd 5/7, black=0x100, line_len=16, 20 samples with continuous s_valid -> each pixel shows dac 0x100 for 4 cycles then the sample; clpdm high for pix 0..5; done exactly once.
REQ-037 Plain run: period=4, samples 0x3FFF and 0x0001 (the second with s_last) -> each held for 4 cycles; busy falls with done.
REQ-038 Underrun: s_valid dropped for one pixel slot -> that pixel shows black for all cycles, underrun=1, the following sample appears normally.
REQ-039 Bad configuration: start with period=3 -> cfg_err pulse, busy stays 0.
REQ-040 Abort during pixel 5 -> next cycle busy=0, clk/shp/shd=1, clpdm=0, no done pulse.
REQ-041 Reset: n_rst pulsed mid-run -> all outputs at reset values immediately; a new start then runs normally.
